// File: rtl/alu_issue_unit.sv
// ALU issue unit: 8x8 register file, single in-flight instruction,
// operands held for ALU_WAIT cycles, then RESULT written back.
module alu_issue_unit #(
  parameter int ALU_WAIT = 2
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       INSTR_VALID,
  output logic       INSTR_READY,
  input  logic [2:0] INSTR_SEL,
  input  logic [2:0] INSTR_DEST,
  input  logic [2:0] INSTR_SRC1,
  input  logic [2:0] INSTR_SRC2,
  input  logic [7:0] INSTR_IMM,
  input  logic       INSTR_USE_IMM,
  output logic [7:0] OP1,
  output logic [7:0] OP2,
  output logic [2:0] SEL,
  input  logic [7:0] RESULT,
  output logic       DONE,
  input  logic [2:0] DBG_ADDR,
  output logic [7:0] DBG_DATA
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] regs_q [8];
  logic [7:0] regs_d [8];
  logic [7:0] op1_q, op1_d;
  logic [7:0] op2_q, op2_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] dest_q, dest_d;
  logic [2:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic       accept;

  assign INSTR_READY = (state_q == IDLE);
  assign accept      = INSTR_READY && INSTR_VALID;

  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    sel_d   = sel_q;
    dest_d  = dest_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op1_d   = regs_q[INSTR_SRC1];
          op2_d   = INSTR_USE_IMM ? INSTR_IMM
                                  : regs_q[INSTR_SRC2];
          sel_d   = INSTR_SEL;
          dest_d  = INSTR_DEST;
          cnt_d   = 3'(ALU_WAIT);
          state_d = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = WB;
      end
      WB: begin
        regs_d[dest_q] = RESULT;
        done_d         = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      for (int i = 0; i < 8; i++) regs_q[i] <= 8'd0;
      op1_q   <= 8'd0;
      op2_q   <= 8'd0;
      sel_q   <= 3'd0;
      dest_q  <= 3'd0;
      cnt_q   <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sel_q   <= sel_d;
      dest_q  <= dest_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign OP1      = op1_q;
  assign OP2      = op2_q;
  assign SEL      = sel_q;
  assign DONE     = done_q;
  assign DBG_DATA = regs_q[DBG_ADDR];

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: directed scenarios plus random
// instructions against an array-based register model.
module tb_alu_issue_unit;

  localparam int AW = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic       ready;
  logic [2:0] i_sel, i_dest, i_src1, i_src2;
  logic [7:0] i_imm;
  logic       i_ui;
  logic [7:0] op1, op2;
  logic [2:0] sel;
  logic [7:0] result;
  logic       done;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  int vecs = 0;
  int errs = 0;
  logic [7:0] m [8];

  always #5 clk = ~clk;

  // team ALU: 000 forwards OP2, 001 adds
  assign result = (sel == 3'b001) ? 8'(op1 + op2) : op2;

  alu_issue_unit #(.ALU_WAIT(AW)) dut (
    .CLK(clk), .RESET_N(rst_n),
    .INSTR_VALID(valid), .INSTR_READY(ready),
    .INSTR_SEL(i_sel), .INSTR_DEST(i_dest),
    .INSTR_SRC1(i_src1), .INSTR_SRC2(i_src2),
    .INSTR_IMM(i_imm), .INSTR_USE_IMM(i_ui),
    .OP1(op1), .OP2(op2), .SEL(sel),
    .RESULT(result), .DONE(done),
    .DBG_ADDR(dbg_addr), .DBG_DATA(dbg_data)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    for (int r = 0; r < 8; r++) begin
      dbg_addr = 3'(r);
      #1;
      check($sformatf("reg%0d", r), dbg_data, m[r]);
    end
  endtask

  task automatic scramble();
    valid  = 1'b1;
    i_sel  = 3'($urandom);
    i_dest = 3'($urandom);
    i_src1 = 3'($urandom);
    i_src2 = 3'($urandom);
    i_imm  = 8'($urandom);
    i_ui   = 1'($urandom);
  endtask

  // Issue one instruction and follow it to writeback; returns
  // just after the writeback edge, in the DONE cycle.
  task automatic run(input logic [2:0] s, d, a, b,
                     input logic [7:0] imm, input logic ui,
                     input bit scr);
    logic [7:0] e1, e2, er;
    check("ready_idle", ready, 1);
    e1 = m[a];
    e2 = ui ? imm : m[b];
    er = (s == 3'b001) ? 8'(e1 + e2) : e2;
    valid = 1'b1;
    i_sel = s; i_dest = d; i_src1 = a; i_src2 = b;
    i_imm = imm; i_ui = ui;
    @(posedge clk); #1;
    for (int i = 0; i <= AW; i++) begin
      if (scr) scramble();
      else valid = 1'b0;
      check("ready_busy", ready, 0);
      check("op1", op1, e1);
      check("op2", op2, e2);
      check("sel", sel, s);
      check("done_busy", done, 0);
      @(posedge clk); #1;
    end
    valid = 1'b0;
    check("done_pulse", done, 1);
    check("ready_wb", ready, 1);
    m[d] = er;
    dbg_addr = d;
    #1;
    check("wb_data", dbg_data, er);
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0;
    i_sel = 0; i_dest = 0; i_src1 = 0; i_src2 = 0;
    i_imm = 0; i_ui = 0; dbg_addr = 0;
    for (int r = 0; r < 8; r++) m[r] = 8'd0;
    #23;
    chk_all();
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    @(negedge clk); rst_n = 1'b1;

    run(3'b000, 3'd1, 3'd0, 3'd0, 8'd8, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("done_once", done, 0);
    run(3'b000, 3'd2, 3'd0, 3'd0, 8'd15, 1'b1, 1'b0);
    run(3'b001, 3'd3, 3'd1, 3'd2, 8'd0, 1'b0, 1'b0);
    run(3'b001, 3'd3, 3'd3, 3'd3, 8'd0, 1'b0, 1'b0);
    check("r3_46", m[3], 46);
    @(posedge clk); #1;
    check("done_low", done, 0);
    run(3'b001, 3'd5, 3'd1, 3'd3, 8'd0, 1'b0, 1'b1);
    chk_all();

    // reset in the first EXEC cycle of an ADD into R4
    valid = 1'b1;
    i_sel = 3'b001; i_dest = 3'd4;
    i_src1 = 3'd1; i_src2 = 3'd2; i_ui = 1'b0;
    @(posedge clk); #1;
    valid = 1'b0;
    check("abort_busy", ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready", ready, 1);
    check("abort_op1", op1, 0);
    check("abort_op2", op2, 0);
    check("abort_done", done, 0);
    for (int r = 0; r < 8; r++) m[r] = 8'd0;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_hold_done", done, 0);
      check("rst_hold_ready", ready, 1);
    end
    @(negedge clk); rst_n = 1'b1;
    chk_all();

    for (int n = 0; n < 40; n++) begin
      run(3'($urandom_range(0, 1)), 3'($urandom),
          3'($urandom), 3'($urandom), 8'($urandom),
          1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
        check("gap_done", done, 0);
      end
    end
    chk_all();

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
